// File: rtl/serial_pkg.sv
// Shared types and frame constants for the 8-bit serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_pkg;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 11;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/serial_tx_8b_if.sv
// Byte-in / serial-out bundle for the 8-bit serial transmitter.
// Latency: n/a (wires only).
// Backpressure: in_rdy low holds the producer off while a frame is on the line.
interface serial_tx_8b_if;
  import serial_pkg::*;

  logic [DATA_BITS-1:0] in_;
  logic                 in_val;
  logic                 in_rdy;
  logic                 out;
  logic                 busy;

  modport master (output in_, output in_val, input in_rdy, input out, input busy);
  modport slave  (input in_, input in_val, output in_rdy, output out, output busy);
endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and flags the last cycle of each bit.
// Latency: tick is decoded from the registered count, no input-to-output path.
// Backpressure: none; clear holds the count at 0.
module serial_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  logic [7:0] cnt;

  assign tick = (cnt == LAST);

  // Count within the bit period, restarting at 0 after the last cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= 8'd0;
    end else if (tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/serial_tx_8b.sv
// Serial transmitter: start, 8 data bits LSB first, even parity, stop; BIT_CYCLES per bit.
// Latency: start bit appears on out the cycle after the accepting edge.
// Backpressure: in_rdy only in IDLE; in_val while busy is ignored, nothing is queued.
module serial_tx_8b
  import serial_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  serial_tx_8b_if.slave  bus
);
  tx_state_t            state;
  tx_state_t            state_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx;
  logic                 parity_bit;
  logic                 tick;
  logic                 accept;
  logic                 last_bit;
  logic                 timer_clear;
  logic                 out_d;
  logic                 busy_d;

  // Ready depends only on registered state and reset, never on in_val.
  assign bus.in_rdy  = (state == IDLE) && !reset;
  assign accept      = bus.in_val && bus.in_rdy;
  assign last_bit    = (bit_idx == 3'(DATA_BITS - 1));
  assign timer_clear = (state == IDLE);
  assign bus.out     = out_d;
  assign bus.busy    = busy_d;

  serial_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the byte and its parity on accept; shift one bit out per DATA bit period.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg  <= '0;
      bit_idx    <= 3'd0;
      parity_bit <= 1'b0;
    end else if (accept) begin
      shift_reg  <= bus.in_;
      bit_idx    <= 3'd0;
      parity_bit <= even_parity(bus.in_);
    end else if ((state == DATA) && tick) begin
      shift_reg  <= shift_reg >> 1;
      bit_idx    <= bit_idx + 3'd1;
    end
  end

  // Next-state: each non-idle state lasts whole bit periods; DATA lasts eight of them.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && last_bit) state_nxt = PARITY;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line level and busy decoded from registered state only.
  always_comb begin
    out_d  = IDLE_LEVEL;
    busy_d = 1'b1;
    case (state)
      IDLE:    begin out_d = IDLE_LEVEL; busy_d = 1'b0; end
      START:   out_d = 1'b0;
      DATA:    out_d = shift_reg[0];
      PARITY:  out_d = parity_bit;
      STOP:    out_d = 1'b1;
      default: begin out_d = IDLE_LEVEL; busy_d = 1'b0; end
    endcase
  end
endmodule

// File: tb/tb_serial_tx_8b.sv
// Bench for serial_tx_8b: directed frame table plus per-cycle reference model.
// Two instances: BIT_CYCLES=4 (directed) and BIT_CYCLES=1 (random bytes).
module tb_serial_tx_8b;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_tx_8b_if bus4();
  serial_tx_8b_if bus1();

  serial_tx_8b #(.BIT_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  serial_tx_8b #(.BIT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame bit k = {stop, parity, data[7:0], start}[k], held BIT_CYCLES cycles.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  function automatic int bc_of(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  bit         m_act[2];
  int         m_pos[2];
  logic [10:0] m_frame[2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic       v;
      logic [7:0] d;
      v = (u == 0) ? bus4.in_val : bus1.in_val;
      d = (u == 0) ? bus4.in_ : bus1.in_;
      if (reset) begin
        m_act[u] = 1'b0;
        m_pos[u] = 0;
      end else if (m_act[u]) begin
        m_pos[u] = m_pos[u] + 1;
        if (m_pos[u] == 11 * bc_of(u)) m_act[u] = 1'b0;
      end else if (v) begin
        m_act[u]   = 1'b1;
        m_pos[u]   = 0;
        m_frame[u] = frame_of(d);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        logic eo, o, b, r;
        eo = m_act[u] ? m_frame[u][m_pos[u] / bc_of(u)] : 1'b1;
        o  = (u == 0) ? bus4.out : bus1.out;
        b  = (u == 0) ? bus4.busy : bus1.busy;
        r  = (u == 0) ? bus4.in_rdy : bus1.in_rdy;
        chk($sformatf("model%0d_out", bc_of(u)), {31'd0, o}, {31'd0, eo});
        chk($sformatf("model%0d_busy", bc_of(u)), {31'd0, b}, {31'd0, m_act[u]});
        chk($sformatf("model%0d_rdy", bc_of(u)), {31'd0, r}, {31'd0, (!m_act[u] && !reset)});
      end
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;   // bit k = k-th frame bit on the line
  } vec_t;

  vec_t vecs[4];

  // Send one byte on the BIT_CYCLES=4 instance and compare every cycle to the table.
  task automatic send_frame(input logic [7:0] b, input logic [10:0] exp);
    @(posedge clk); #1;
    bus4.in_    = b;
    bus4.in_val = 1'b1;
    @(posedge clk); #1;
    bus4.in_val = 1'b0;
    bus4.in_    = ~b;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      chk($sformatf("frame_%02h_out%0d", b, i), {31'd0, bus4.out}, {31'd0, exp[i / 4]});
      chk($sformatf("frame_%02h_busy%0d", b, i), {31'd0, bus4.busy}, 32'd1);
      bus4.in_val = (i >= 10 && i < 14);
      bus4.in_    = 8'($urandom);
    end
    @(negedge clk);
    chk($sformatf("frame_%02h_done_busy", b), {31'd0, bus4.busy}, 32'd0);
    chk($sformatf("frame_%02h_done_rdy", b), {31'd0, bus4.in_rdy}, 32'd1);
  endtask

  initial begin
    int accepts;
    int cyc;
    logic [10:0] f3c, fc3, fff;

    vecs[0] = '{data: 8'hA5, frame: 11'b101_0100_1010};
    vecs[1] = '{data: 8'h01, frame: 11'b110_0000_0010};
    vecs[2] = '{data: 8'h00, frame: 11'b100_0000_0000};
    vecs[3] = '{data: 8'hFF, frame: 11'b101_1111_1110};
    f3c = 11'b100_0111_1000;
    fc3 = 11'b101_1000_0110;
    fff = 11'b101_1111_1110;

    bus4.in_ = 8'd0; bus4.in_val = 1'b0;
    bus1.in_ = 8'd0; bus1.in_val = 1'b0;

    // Reset state.
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out", {31'd0, bus4.out}, 32'd1);
    chk("rst_busy", {31'd0, bus4.busy}, 32'd0);
    chk("rst_rdy", {31'd0, bus4.in_rdy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle with no valid input.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_out", {31'd0, bus4.out}, 32'd1);
      chk("idle_busy", {31'd0, bus4.busy}, 32'd0);
      chk("idle_rdy", {31'd0, bus4.in_rdy}, 32'd1);
    end

    // Frame table.
    for (int k = 0; k < 4; k++) send_frame(vecs[k].data, vecs[k].frame);

    // Back-to-back with in_val held high and in_ toggling mid-frame.
    @(posedge clk); #1;
    bus4.in_    = 8'h3C;
    bus4.in_val = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_3c_out%0d", i), {31'd0, bus4.out}, {31'd0, f3c[i / 4]});
      bus4.in_ = (i < 40) ? 8'($urandom) : 8'hC3;
    end
    @(negedge clk);
    chk("b2b_gap_out", {31'd0, bus4.out}, 32'd1);
    chk("b2b_gap_rdy", {31'd0, bus4.in_rdy}, 32'd1);
    chk("b2b_gap_busy", {31'd0, bus4.busy}, 32'd0);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_c3_out%0d", i), {31'd0, bus4.out}, {31'd0, fc3[i / 4]});
      chk($sformatf("b2b_c3_busy%0d", i), {31'd0, bus4.busy}, 32'd1);
      bus4.in_val = 1'b0;
      bus4.in_    = 8'($urandom);
    end
    @(negedge clk);
    chk("b2b_end_busy", {31'd0, bus4.busy}, 32'd0);

    // Reset in the middle of a 0xFF frame.
    @(posedge clk); #1;
    bus4.in_    = 8'hFF;
    bus4.in_val = 1'b1;
    @(posedge clk); #1;
    bus4.in_val = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("abort_pre_out%0d", i), {31'd0, bus4.out}, {31'd0, fff[i / 4]});
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out", {31'd0, bus4.out}, 32'd1);
    chk("abort_busy", {31'd0, bus4.busy}, 32'd0);
    chk("abort_rdy_in_reset", {31'd0, bus4.in_rdy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rdy_after", {31'd0, bus4.in_rdy}, 32'd1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("abort_no_resume_out", {31'd0, bus4.out}, 32'd1);
      chk("abort_no_resume_busy", {31'd0, bus4.busy}, 32'd0);
    end

    // BIT_CYCLES=1: random bytes and random valid, checked by the model every cycle.
    accepts = 0;
    cyc     = 0;
    while (accepts < 20 && cyc < 3000) begin
      @(posedge clk); #1;
      bus1.in_val = ($urandom_range(0, 3) != 0);
      bus1.in_    = 8'($urandom);
      @(negedge clk);
      if (bus1.in_val && bus1.in_rdy) accepts++;
      cyc++;
    end
    chk("bc1_accepts", accepts, 32'd20);
    @(posedge clk); #1;
    bus1.in_val = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bc1_end_busy", {31'd0, bus1.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/serial_tx_8b.md
SERIAL_TX_8B -- requirements
Module: serial_tx_8b

Interface
REQ-001 Parameter: BIT_CYCLES, default 4, clock cycles per serial bit; legal range 1..255.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_  input  8  parallel byte to transmit; sampled only on a handshake.
REQ-005 in_val  input  1  in_ holds a valid byte.
REQ-006 in_rdy  output  1  transmitter accepts a byte this cycle.
REQ-007 out  output  1  serial line; idle level 1.
REQ-008 busy  output  1  a frame is in progress.

Function
REQ-009 The design SHALL use exactly one clock (clk); reset SHALL be synchronous and active-high.
REQ-010 Handshake: a byte SHALL be accepted on a rising edge where in_val=1 and in_rdy=1; no other edge accepts data.
REQ-011 in_rdy SHALL be 1 exactly when the state is IDLE and reset=0; in_rdy SHALL NOT depend combinationally on in_val.
REQ-012 The accepted byte SHALL be captured into an internal shift register; later changes on in_ SHALL NOT affect the frame.
REQ-013 Frame format, in order: start bit 0; data bits in_[0] through in_[7] (LSB first); even-parity bit (XOR of the 8 data bits); stop bit 1.
REQ-014 Each frame bit SHALL be driven on out for exactly BIT_CYCLES consecutive cycles, giving 11*BIT_CYCLES cycles per frame.
REQ-015 Latency: the start bit SHALL appear on out in the first cycle after the accepting edge.
REQ-016 States: IDLE, START, DATA, PARITY, STOP.
REQ-017 State transitions: IDLE->START on handshake; START->DATA after BIT_CYCLES cycles; DATA->PARITY after 8 bits; PARITY->STOP after BIT_CYCLES cycles; STOP->IDLE after BIT_CYCLES cycles.
REQ-018 out SHALL be 1 in IDLE and STOP, 0 in START, shift_reg[0] in DATA, and the parity bit in PARITY.
REQ-019 out and busy SHALL be decoded from registered state only; there SHALL be no combinational path from any input to out or busy.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 A bit-period counter SHALL count 0..BIT_CYCLES-1 and wrap to 0. A bit-index counter SHALL count 0..7 in DATA. The shift register SHALL shift right at each DATA bit boundary.
REQ-022 in_val asserted while busy=1 SHALL be ignored; the byte is neither queued nor dropped silently into the frame.
REQ-023 Back-to-back bytes: with in_val held at 1, there SHALL be exactly one IDLE cycle (out=1, in_rdy=1) between frames; the next start bit follows immediately after it.
REQ-024 BIT_CYCLES=1 SHALL work, with each bit lasting one cycle.

Reset
REQ-025 While reset=1 at a rising edge, the next state SHALL be IDLE, with both counters at 0 and the shift register at 0.
REQ-026 After reset: out=1, busy=0, in_rdy=0 while reset is high, and in_rdy=1 in the first cycle with reset=0.
REQ-027 A reset asserted mid-frame SHALL abort the frame; out SHALL be 1 from the cycle after the reset edge, and no partial frame resumes.

Structure
REQ-028 A shared package serial_pkg SHALL hold the state enum type and the frame constants (DATA_BITS=8, FRAME_BITS=11, IDLE_LEVEL=1).
REQ-029 One sub-module, serial_bit_timer, SHALL implement the BIT_CYCLES counter. It takes parameter BIT_CYCLES and ports clk, reset, clear, and tick (1 in the last cycle of each bit period).
REQ-030 The FSM, shift register, bit index and parity logic SHALL reside in serial_tx_8b.

Verification (BIT_CYCLES=4 unless stated)
REQ-031 Reset, then in_val=0 for 10 cycles -> out=1, busy=0, in_rdy=1 throughout.
REQ-032 Send 0xA5 -> out, each bit for 4 cycles: 0,1,0,1,0,0,1,0,1,0,1. Total 44 busy cycles, then in_rdy=1.
REQ-033 Send 0x01 -> parity bit 1. Send 0x00 -> data and parity bits all 0, stop bit 1.
REQ-034 Hold in_val=1 with 0x3C then 0xC3; toggle in_ mid-frame -> two correct frames separated by exactly one IDLE cycle, and in_ changes have no effect.
REQ-035 Assert reset at cycle 20 of a 0xFF frame -> out=1 from the next cycle, busy=0, and in_rdy=1 after reset drops.
REQ-036 Set BIT_CYCLES=1 and send 20 random bytes -> out matches a cycle-accurate reference model every cycle.
